// File: rtl/mcpu_mem_pre_arb.sv
// Two-client pre-arbiter between the boot preloader and the core client, feeding the LTC.
// An in-order owner FIFO steers each LTC response pulse back to the client that issued it.
module mcpu_mem_pre_arb #(
  parameter int OWNER_DEPTH  = 8,
  parameter int PRE_PRIORITY = 1
) (
  input  logic         clkrst_mem_clk,
  input  logic         clkrst_mem_rst_n,
  input  logic         pre2core_done,
  input  logic         pre2arb_valid,
  input  logic [2:0]   pre2arb_opcode,
  input  logic [26:0]  pre2arb_addr,
  input  logic [255:0] pre2arb_wdata,
  input  logic [31:0]  pre2arb_wbe,
  output logic         pre2arb_stall,
  output logic         pre2arb_rvalid,
  input  logic         cli2arb_valid,
  input  logic [2:0]   cli2arb_opcode,
  input  logic [26:0]  cli2arb_addr,
  input  logic [255:0] cli2arb_wdata,
  input  logic [31:0]  cli2arb_wbe,
  output logic         cli2arb_stall,
  output logic         cli2arb_rvalid,
  output logic [255:0] cli2arb_rdata,
  output logic         arb2ltc_valid,
  output logic [2:0]   arb2ltc_opcode,
  output logic [26:0]  arb2ltc_addr,
  output logic [255:0] arb2ltc_wdata,
  output logic [31:0]  arb2ltc_wbe,
  input  logic         arb2ltc_stall,
  input  logic         arb2ltc_rvalid,
  input  logic [255:0] arb2ltc_rdata
);

  localparam int PW = $clog2(OWNER_DEPTH);
  localparam int CW = PW + 1;

  logic [OWNER_DEPTH-1:0] r_owner;
  logic [PW-1:0]          r_rdPtr;
  logic [PW-1:0]          r_wrPtr;
  logic [CW-1:0]          r_count;
  logic                   r_lastCli;

  logic w_empty, w_pop, w_full, w_head, w_push;
  logic w_grantPre, w_grantCli, w_baseStall;

  assign w_empty = (r_count == '0);
  assign w_pop   = arb2ltc_rvalid && !w_empty;
  assign w_head  = r_owner[r_rdPtr];
  // A response in the same cycle frees a slot, so a full FIFO does not block.
  assign w_full  = (r_count == CW'(OWNER_DEPTH)) && !w_pop;

  always_comb begin
    w_grantPre = 1'b0;
    w_grantCli = 1'b0;
    if (pre2arb_valid && cli2arb_valid) begin
      if ((PRE_PRIORITY != 0) && !pre2core_done) w_grantPre = 1'b1;
      else if (r_lastCli)                        w_grantPre = 1'b1;
      else                                       w_grantCli = 1'b1;
    end else if (pre2arb_valid) begin
      w_grantPre = 1'b1;
    end else if (cli2arb_valid) begin
      w_grantCli = 1'b1;
    end
  end

  always_comb begin
    arb2ltc_opcode = '0;
    arb2ltc_addr   = '0;
    arb2ltc_wdata  = '0;
    arb2ltc_wbe    = '0;
    if (w_grantPre) begin
      arb2ltc_opcode = pre2arb_opcode;
      arb2ltc_addr   = pre2arb_addr;
      arb2ltc_wdata  = pre2arb_wdata;
      arb2ltc_wbe    = pre2arb_wbe;
    end else if (w_grantCli) begin
      arb2ltc_opcode = cli2arb_opcode;
      arb2ltc_addr   = cli2arb_addr;
      arb2ltc_wdata  = cli2arb_wdata;
      arb2ltc_wbe    = cli2arb_wbe;
    end
  end

  assign arb2ltc_valid = (pre2arb_valid || cli2arb_valid) && !w_full;
  assign w_baseStall   = arb2ltc_stall || w_full;
  assign pre2arb_stall = (pre2arb_valid && w_grantCli) || w_baseStall;
  assign cli2arb_stall = (cli2arb_valid && w_grantPre) || w_baseStall;
  assign w_push        = arb2ltc_valid && !arb2ltc_stall;

  assign pre2arb_rvalid = w_pop && !w_head;
  assign cli2arb_rvalid = w_pop && w_head;
  assign cli2arb_rdata  = (!w_empty && w_head) ? arb2ltc_rdata : '0;

  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      r_owner   <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_lastCli <= 1'b1;
    end else begin
      if (w_push) begin
        r_owner[r_wrPtr] <= w_grantCli;
        r_wrPtr          <= r_wrPtr + PW'(1);
        r_lastCli        <= w_grantCli;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_mcpu_mem_pre_arb.sv
// Self-checking bench for mcpu_mem_pre_arb: a directed vector table walked from reset,
// then hand-written sequences for FIFO-full, mid-operation reset and grant-state reset.
module tb_mcpu_mem_pre_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         done;
  logic         pv, cv;
  logic [2:0]   pOp, cOp;
  logic [26:0]  pAddr, cAddr;
  logic [255:0] pWdata, cWdata;
  logic [31:0]  pWbe, cWbe;
  logic         pStall, cStall, pRvalid, cRvalid;
  logic [255:0] cRdata;
  logic         lValid;
  logic [2:0]   lOp;
  logic [26:0]  lAddr;
  logic [255:0] lWdata;
  logic [31:0]  lWbe;
  logic         lStall, lRvalid;
  logic [255:0] lRdata;

  int passCount  = 0;
  int totalCount = 0;

  localparam logic [2:0]   PRE_OP    = 3'd1;
  localparam logic [2:0]   CLI_OP    = 3'd2;
  localparam logic [255:0] PRE_WDATA = {32{8'h11}};
  localparam logic [255:0] CLI_WDATA = {32{8'h22}};
  localparam logic [31:0]  PRE_WBE   = 32'hFFFF_FFFF;
  localparam logic [31:0]  CLI_WBE   = 32'h0000_FFFF;

  always #5 clk = ~clk;

  mcpu_mem_pre_arb #(.OWNER_DEPTH(8), .PRE_PRIORITY(1)) dut (
    .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n), .pre2core_done(done),
    .pre2arb_valid(pv), .pre2arb_opcode(pOp), .pre2arb_addr(pAddr),
    .pre2arb_wdata(pWdata), .pre2arb_wbe(pWbe), .pre2arb_stall(pStall),
    .pre2arb_rvalid(pRvalid),
    .cli2arb_valid(cv), .cli2arb_opcode(cOp), .cli2arb_addr(cAddr),
    .cli2arb_wdata(cWdata), .cli2arb_wbe(cWbe), .cli2arb_stall(cStall),
    .cli2arb_rvalid(cRvalid), .cli2arb_rdata(cRdata),
    .arb2ltc_valid(lValid), .arb2ltc_opcode(lOp), .arb2ltc_addr(lAddr),
    .arb2ltc_wdata(lWdata), .arb2ltc_wbe(lWbe), .arb2ltc_stall(lStall),
    .arb2ltc_rvalid(lRvalid), .arb2ltc_rdata(lRdata)
  );

  typedef struct {
    logic        pv;
    logic [26:0] pa;
    logic        cv;
    logic [26:0] ca;
    logic        done;
    logic        ls;
    logic        rv;
    logic [7:0]  rd;
    logic        eLv;
    logic [2:0]  eOp;
    logic [26:0] eAddr;
    logic        ePs;
    logic        eCs;
    logic        ePr;
    logic        eCr;
    logic [7:0]  eRd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ipv, input logic [26:0] ipa, input logic icv,
                              input logic [26:0] ica, input logic idone, input logic ils,
                              input logic irv, input logic [7:0] ird, input logic eLv,
                              input logic [2:0] eOp, input logic [26:0] eAddr, input logic ePs,
                              input logic eCs, input logic ePr, input logic eCr,
                              input logic [7:0] eRd);
    vec_t v;
    v.pv = ipv; v.pa = ipa; v.cv = icv; v.ca = ica; v.done = idone; v.ls = ils;
    v.rv = irv; v.rd = ird; v.eLv = eLv; v.eOp = eOp; v.eAddr = eAddr;
    v.ePs = ePs; v.eCs = eCs; v.ePr = ePr; v.eCr = eCr; v.eRd = eRd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    pv = v.pv; pAddr = v.pa; cv = v.cv; cAddr = v.ca; done = v.done;
    lStall = v.ls; lRvalid = v.rv; lRdata = {32{v.rd}};
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    logic [255:0] expWdata;
    logic [31:0]  expWbe;
    tag = $sformatf("v%0d", idx);
    expWdata = (v.eOp == PRE_OP) ? PRE_WDATA : (v.eOp == CLI_OP) ? CLI_WDATA : '0;
    expWbe   = (v.eOp == PRE_OP) ? PRE_WBE   : (v.eOp == CLI_OP) ? CLI_WBE   : '0;
    checkOutput({tag, ".ltcValid"}, 256'(lValid), 256'(v.eLv));
    checkOutput({tag, ".ltcOpcode"}, 256'(lOp), 256'(v.eOp));
    checkOutput({tag, ".ltcAddr"}, 256'(lAddr), 256'(v.eAddr));
    checkOutput({tag, ".ltcWdata"}, lWdata, expWdata);
    checkOutput({tag, ".ltcWbe"}, 256'(lWbe), 256'(expWbe));
    checkOutput({tag, ".preStall"}, 256'(pStall), 256'(v.ePs));
    checkOutput({tag, ".cliStall"}, 256'(cStall), 256'(v.eCs));
    checkOutput({tag, ".preRvalid"}, 256'(pRvalid), 256'(v.ePr));
    checkOutput({tag, ".cliRvalid"}, 256'(cRvalid), 256'(v.eCr));
    checkOutput({tag, ".cliRdata"}, cRdata, {32{v.eRd}});
  endtask

  task automatic setIdle();
    pv = 0; cv = 0; lStall = 0; lRvalid = 0; lRdata = '0; pAddr = '0; cAddr = '0;
  endtask

  task automatic resetDut();
    setIdle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pOp = PRE_OP; cOp = CLI_OP; pWdata = PRE_WDATA; cWdata = CLI_WDATA;
    pWbe = PRE_WBE; cWbe = CLI_WBE; done = 0;
    resetDut();

    //           pv pa      cv ca      dn ls rv rd     eLv eOp eAddr   ePs eCs ePr eCr eRd
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   0, 0, 0, 8'h00, 0, 3'd0, 27'h0,   0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h0,  1, 27'h100, 0, 0, 0, 8'h00, 1, 3'd1, 27'h0,   0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h1,  1, 27'h100, 0, 0, 0, 8'h00, 1, 3'd1, 27'h1,   0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h2,  1, 27'h100, 0, 0, 0, 8'h00, 1, 3'd1, 27'h2,   0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h3,  1, 27'h100, 0, 0, 0, 8'h00, 1, 3'd1, 27'h3,   0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h4,  1, 27'h100, 1, 0, 0, 8'h00, 1, 3'd2, 27'h100, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h4,  1, 27'h101, 1, 0, 0, 8'h00, 1, 3'd1, 27'h4,   0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hBB, 0, 3'd0, 27'h0,   0, 0, 0, 1, 8'hBB));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hCC, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hEE, 0, 3'd0, 27'h0,   0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 27'h10, 0, 27'h0,   1, 0, 0, 8'h00, 1, 3'd1, 27'h10,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  1, 27'h20,  1, 0, 0, 8'h00, 1, 3'd2, 27'h20,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 0, 8'h00, 0, 3'd0, 27'h0,   0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hAA, 0, 3'd0, 27'h0,   0, 0, 0, 1, 8'hAA));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 27'h0, 1, 27'h30, 1, 1, 0, 8'h00, 1, 3'd2, 27'h30, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  1, 27'h30,  1, 0, 0, 8'h00, 1, 3'd2, 27'h30,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 27'h0,  0, 27'h0,   1, 0, 1, 8'hDD, 0, 3'd0, 27'h0,   0, 0, 0, 1, 8'hDD));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkVector(i, vecs[i]);
      nextCycle();
    end

    // Fill the owner FIFO with preloader requests, then exercise push+pop while full.
    resetDut();
    done = 1;
    pv = 1;
    for (int i = 0; i < 8; i++) begin
      pAddr = 27'h40 + 27'(i);
      #2 checkOutput($sformatf("fill%0d.ltcValid", i), 256'(lValid), 256'(1));
      nextCycle();
    end
    pAddr = 27'h48;
    #2;
    checkOutput("full.ltcValid", 256'(lValid), 256'(0));
    checkOutput("full.preStall", 256'(pStall), 256'(1));
    checkOutput("full.cliStall", 256'(cStall), 256'(1));
    lRvalid = 1;
    #1;
    checkOutput("fullPop.ltcValid", 256'(lValid), 256'(1));
    checkOutput("fullPop.preStall", 256'(pStall), 256'(0));
    checkOutput("fullPop.preRvalid", 256'(pRvalid), 256'(1));
    checkOutput("fullPop.ltcAddr", 256'(lAddr), 256'(27'h48));
    nextCycle();
    lRvalid = 0;
    #1;
    checkOutput("stillFull.ltcValid", 256'(lValid), 256'(0));
    pv = 0;
    lRvalid = 1;
    for (int i = 0; i < 8; i++) begin
      #1 checkOutput($sformatf("drain%0d.preRvalid", i), 256'(pRvalid), 256'(1));
      checkOutput($sformatf("drain%0d.cliRvalid", i), 256'(cRvalid), 256'(0));
      nextCycle();
    end
    #1 checkOutput("emptyPop.preRvalid", 256'(pRvalid), 256'(0));
    checkOutput("emptyPop.cliRvalid", 256'(cRvalid), 256'(0));
    nextCycle();

    // Three outstanding tags (core, core, pre) are discarded by a mid-operation reset.
    setIdle();
    done = 1;
    cv = 1; cAddr = 27'h50;
    nextCycle();
    nextCycle();
    cv = 0; pv = 1; pAddr = 27'h60;
    nextCycle();
    pv = 0;
    rst_n = 0;
    lRvalid = 1; lRdata = {32{8'h77}};
    #1;
    checkOutput("inReset.preRvalid", 256'(pRvalid), 256'(0));
    checkOutput("inReset.cliRvalid", 256'(cRvalid), 256'(0));
    checkOutput("inReset.cliRdata", cRdata, 256'(0));
    nextCycle();
    lRvalid = 0;
    rst_n = 1;
    pv = 1; pAddr = 27'h70; cv = 1; cAddr = 27'h71;
    #1;
    checkOutput("postReset.ltcAddr", 256'(lAddr), 256'(27'h70));
    checkOutput("postReset.cliStall", 256'(cStall), 256'(1));
    nextCycle();
    pv = 0; cv = 0;
    lRvalid = 1; lRdata = {32{8'h99}};
    #1;
    checkOutput("freshHead.preRvalid", 256'(pRvalid), 256'(1));
    checkOutput("freshHead.cliRvalid", 256'(cRvalid), 256'(0));
    checkOutput("freshHead.cliRdata", cRdata, 256'(0));
    nextCycle();
    setIdle();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
